// File: rtl/upe_pkg.sv
// Shared types and sizing helpers for the uncertainty-propagation engine.
package upe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } upe_state_t;

   // Pipeline flush cycles after the last term, counted down to zero.
   localparam int DRAIN_CYC = 2;

   // Result width: one W*W*W product plus growth for N*N accumulated terms.
   function automatic int zw(input int n, input int w);
      return 3*w - 2 + $clog2(n*n);
   endfunction

   function automatic int nterms(input int n, input logic sym);
      return sym ? (n*(n+1))/2 : n*n;
   endfunction

endpackage

// File: rtl/upe_mac.sv
// Two-stage signed multiply pipeline (g_a*g_b, then *c) feeding an accumulator.
module upe_mac #(
   parameter int W  = 16,
   parameter int ZW = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 vin,
   input  logic signed [W-1:0]  g_a,
   input  logic signed [W-1:0]  g_b,
   input  logic signed [W-1:0]  c,
   input  logic                 dbl,
   output logic signed [ZW-1:0] acc
);

   localparam int P1W = 2*W;
   localparam int EW  = (ZW > 3*W) ? ZW : 3*W;

   logic                  v1;
   logic                  v2;
   logic                  dbl1;
   logic signed [P1W-1:0] p1;
   logic signed [W-1:0]   c1;
   logic signed [ZW-1:0]  p2;
   logic signed [EW-1:0]  prod;
   logic signed [EW-1:0]  prod_x;

   // The true product magnitude never exceeds 2^(3W-3), so the doubled
   // value always fits in ZW bits.
   always_comb begin
      prod   = EW'(p1) * EW'(c1);
      prod_x = dbl1 ? (prod <<< 1) : prod;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         dbl1 <= 1'b0;
         p1   <= '0;
         c1   <= '0;
         p2   <= '0;
         acc  <= '0;
      end else begin
         v1   <= vin;
         dbl1 <= dbl;
         p1   <= P1W'(g_a) * P1W'(g_b);
         c1   <= c;
         v2   <= v1;
         p2   <= prod_x[ZW-1:0];
         if (v2) begin
            acc <= acc + p2;
         end
      end
   end

endmodule

// File: rtl/upe_seq.sv
// Sequential propagated-variance engine: var_z = g^T * C * g, one matrix term
// per cycle through a shared multiply pipeline, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high; operands latched on in_valid
// RUN   | one (i,j) term issued per cycle
// DRAIN | flushing the multiply/accumulate pipeline
// DONE  | out_valid high until out_ready
module upe_seq
   import upe_pkg::*;
#(
   parameter  int N  = 2,
   parameter  int W  = 16,
   localparam int ZW = zw(N, W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sym,
   input  logic [N*W-1:0]       grad,
   input  logic [N*N*W-1:0]     cov,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [ZW-1:0] var_z,
   output logic                 busy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (N > 1) ? $clog2(N*N) : 1;
   localparam int TW = $clog2(N*N + 1);
   localparam int DW = 2;

   upe_state_t           state;
   upe_state_t           state_n;
   logic signed [W-1:0]  g_q [N];
   logic signed [W-1:0]  c_q [N*N];
   logic                 sym_q;
   logic [IW-1:0]        idx_i;
   logic [IW-1:0]        idx_j;
   logic [CW-1:0]        cidx;
   logic [TW-1:0]        term_cnt;
   logic [DW-1:0]        drain_cnt;
   logic                 accept;
   logic                 issue;
   logic                 last_term;
   logic                 dbl;
   logic signed [W-1:0]  op_a;
   logic signed [W-1:0]  op_b;
   logic signed [W-1:0]  op_c;
   logic signed [ZW-1:0] acc;

   assign accept    = (state == IDLE) && in_valid;
   assign issue     = (state == RUN);
   assign last_term = (term_cnt == TW'(1));

   always_comb begin
      cidx = CW'(idx_i) * CW'(N) + CW'(idx_j);
      op_a = g_q[idx_i];
      op_b = g_q[idx_j];
      op_c = c_q[cidx];
      dbl  = sym_q && (idx_i != idx_j);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)           state_n = RUN;
         RUN:     if (last_term)          state_n = DRAIN;
         DRAIN:   if (drain_cnt == '0)    state_n = DONE;
         DONE:    if (out_ready)          state_n = IDLE;
         default:                         state_n = IDLE;
      endcase
   end

   // Operand latches only load on the accept edge; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < N; k++) begin
            g_q[k] <= grad[k*W +: W];
         end
         for (int k = 0; k < N*N; k++) begin
            c_q[k] <= cov[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         var_z     <= '0;
         sym_q     <= 1'b0;
         idx_i     <= '0;
         idx_j     <= '0;
         term_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_n;
         in_ready  <= (state_n == IDLE);
         out_valid <= (state_n == DONE);
         busy      <= (state_n == RUN) || (state_n == DRAIN);
         if ((state_n == DONE) && (state != DONE)) begin
            var_z <= acc;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sym_q    <= sym;
                  idx_i    <= '0;
                  idx_j    <= '0;
                  term_cnt <= TW'(nterms(N, sym));
               end
            end
            RUN: begin
               term_cnt <= term_cnt - TW'(1);
               if (last_term) begin
                  drain_cnt <= DW'(DRAIN_CYC);
               end
               // Row wrap: symmetric walk restarts on the diagonal of the next row.
               if (idx_j == IW'(N-1)) begin
                  idx_i <= idx_i + IW'(1);
                  idx_j <= sym_q ? (idx_i + IW'(1)) : '0;
               end else begin
                  idx_j <= idx_j + IW'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   upe_mac #(
      .W  (W),
      .ZW (ZW)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .vin   (issue),
      .g_a   (op_a),
      .g_b   (op_b),
      .c     (op_c),
      .dbl   (dbl),
      .acc   (acc)
   );

endmodule

// File: tb/tb_upe_seq.sv
// Bench for upe_seq at N=2, W=16: vector table plus scoreboard on results.
module tb_upe_seq;

   localparam int N  = 2;
   localparam int W  = 16;
   localparam int ZW = 48;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              sym = 1'b0;
   logic [N*W-1:0]    grad = '0;
   logic [N*N*W-1:0]  cov = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [ZW-1:0]     var_z;
   logic              busy;

   upe_seq #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sym       (sym),
      .grad      (grad),
      .cov       (cov),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .var_z     (var_z),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt++;

   typedef struct {
      logic        s;
      logic [31:0] g;
      logic [63:0] c;
      logic [47:0] e;
      int          lat;
   } vec_t;

   typedef struct {
      logic [47:0] e;
      int          lat;
      int          t;
   } sb_t;

   sb_t  sbq[$];
   vec_t tbl[6];
   int   total = 0;
   int   bad = 0;
   logic ov_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] model(input logic s, input logic [31:0] g, input logic [63:0] c);
      longint a = 0;
      longint t;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!(s && j < i)) begin
               t = longint'($signed(g[i*16 +: 16])) * longint'($signed(g[j*16 +: 16]))
                   * longint'($signed(c[(i*N+j)*16 +: 16]));
               if (s && i != j) t = t * 2;
               a += t;
            end
         end
      end
      return a[47:0];
   endfunction

   // Scoreboard check on each new result.
   always @(negedge clk) begin
      sb_t s;
      if (rst_n && out_valid && !ov_prev) begin
         if (sbq.size() == 0) begin
            chk("unexpected_result", 64'(sbq.size()), 64'd1);
         end else begin
            s = sbq.pop_front();
            chk("var_z", var_z, s.e);
            chk("latency", 64'(ecnt - s.t), 64'(s.lat));
         end
      end
      ov_prev = out_valid;
   end

   task automatic send(input logic s, input logic [31:0] g, input logic [63:0] c,
                       input logic [47:0] e, input int lat);
      int n = 0;
      sb_t ent;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_valid = 1'b1;
      sym  = s;
      grad = g;
      cov  = c;
      ent.e = e;
      ent.lat = lat;
      ent.t = ecnt + 1;
      sbq.push_back(ent);
      @(negedge clk);
      in_valid = 1'b0;
      sym  = ~s;
      grad = $urandom;
      cov  = {$urandom, $urandom};
      chk("busy_after_accept", 64'(busy), 64'd1);
      chk("in_ready_after_accept", 64'(in_ready), 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("pending_results", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      logic        rs;
      logic [31:0] rg;
      logic [63:0] rc;
      int          n;

      tbl[0] = '{1'b0, {16'd3, 16'd2}, {16'd7, 16'd1, 16'd1, 16'd5}, 48'd95, 7};
      tbl[1] = '{1'b1, {16'd3, 16'd2}, {16'd7, 16'd100, 16'd1, 16'd5}, 48'd95, 6};
      tbl[2] = '{1'b0, {16'd3, 16'd2}, {16'd7, 16'd100, 16'd1, 16'd5}, 48'd689, 7};
      tbl[3] = '{1'b0, {16'd2, 16'hFFFF}, {16'd9, 16'hFFFD, 16'hFFFD, 16'd4}, 48'd52, 7};
      tbl[4] = '{1'b0, {2{16'h8000}}, {4{16'h8000}}, 48'h8000_0000_0000, 7};
      tbl[5] = '{1'b1, {2{16'h8000}}, {4{16'h8000}}, 48'h8000_0000_0000, 6};

      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_var_z", var_z, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         send(tbl[k].s, tbl[k].g, tbl[k].c, tbl[k].e, tbl[k].lat);
      end
      drain();

      for (int k = 0; k < 4; k++) begin
         rs = 1'($urandom_range(0, 1));
         rg = $urandom;
         rc = {$urandom, $urandom};
         send(rs, rg, rc, model(rs, rg, rc), rs ? 6 : 7);
      end
      drain();

      // Backpressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      send(tbl[0].s, tbl[0].g, tbl[0].c, tbl[0].e, tbl[0].lat);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_var_z", var_z, 64'd95);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      chk("idle_var_z_hold", var_z, 64'd95);

      // Reset two edges after accept discards the in-flight computation.
      send(tbl[2].s, tbl[2].g, tbl[2].c, tbl[2].e, tbl[2].lat);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_var_z", var_z, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      sbq.delete();
      send(tbl[3].s, tbl[3].g, tbl[3].c, tbl[3].e, tbl[3].lat);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
